// File: rtl/morse_playback_sched.sv
// morse_playback_sched
//   Scans display slots 0..7, selects each playable slot through a one-hot
//   encoder-select bus, captures the Morse symbol the encoder returns and
//   plays it on a single tone/LED line as timed dots, dashes and gaps.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   start        begin playback (honoured only while idle)
//   abort        stop playback, back to idle on the next edge
//   slot_en      per-slot play enable, bit i = slot i
//   seg_out_temp segment codes, slot i = bits [8i+7:8i], 8'hFF = blank
//   sym_bits     Morse elements from the encoder, bit0 first, 1 = dash
//   sym_len      element count from the encoder, 1..5 playable
//   slot_sel     one-hot encoder select, 0 when not selecting
//   tone         1 while a dot or dash is sounding
//   busy         1 whenever not idle
//   cur_slot     index of the slot being scanned
//   done         one-cycle pulse when a scan completes normally
module morse_playback_sched #(
  parameter int UNIT_CYCLES    = 25000000,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  slot_en,
  input  logic [63:0] seg_out_temp,
  input  logic [4:0]  sym_bits,
  input  logic [2:0]  sym_len,
  output logic [7:0]  slot_sel,
  output logic        tone,
  output logic        busy,
  output logic [2:0]  cur_slot,
  output logic        done
);

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  localparam longint DOT_LEN  = longint'(UNIT_CYCLES);
  localparam longint DASH_LEN = longint'(DASH_UNITS) * longint'(UNIT_CYCLES);
  localparam longint CGAP_LEN = longint'(CHAR_GAP_UNITS) * longint'(UNIT_CYCLES);
  localparam longint SET_LEN  = longint'(SETTLE_CYCLES);
  localparam longint MAX_LEN  = lmax(lmax(DOT_LEN, DASH_LEN), lmax(CGAP_LEN, SET_LEN));
  localparam int     CNT_W    = $clog2(MAX_LEN + 1);

  // Counter load values are duration-1: the counter runs down to zero and the
  // state is left on the zero cycle, giving exactly 'duration' cycles.
  localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_LEN - 1);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_LEN - 1);
  localparam logic [CNT_W-1:0] CGAP_LD = CNT_W'(CGAP_LEN - 1);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SET_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SELECT, S_LATCH, S_MARK, S_GAP, S_CGAP, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       slot_n;
  logic [2:0]       elem_idx, elem_n;
  logic [4:0]       sym_r;
  logic [2:0]       len_r;
  logic             capture;
  logic             advance;
  logic [7:0]       slot_byte;
  logic [7:0]       sym_ext;
  logic [7:0]       sel_n;
  logic             tone_n, busy_n, done_n;

  assign slot_byte = seg_out_temp[{cur_slot, 3'b000} +: 8];
  // Zero-extended so any 3-bit element index stays in range.
  assign sym_ext   = {3'b000, sym_r};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_slot <= 3'd0;
      elem_idx <= 3'd0;
      slot_sel <= 8'h00;
      tone     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_slot <= slot_n;
      elem_idx <= elem_n;
      slot_sel <= sel_n;
      tone     <= tone_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Symbol capture is pure data; it is only read after a LATCH has loaded it.
  always_ff @(posedge clk) begin
    if (capture) begin
      sym_r <= sym_bits;
      len_r <= sym_len;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    slot_n  = cur_slot;
    elem_n  = elem_idx;
    capture = 1'b0;
    advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CHECK;
          slot_n  = 3'd0;
        end
      end
      S_CHECK: begin
        if (!slot_en[cur_slot] || slot_byte == 8'hFF) begin
          advance = 1'b1;
        end else begin
          state_n = S_SELECT;
          cnt_n   = SET_LD;
        end
      end
      S_SELECT: begin
        if (cnt == '0) state_n = S_LATCH;
      end
      S_LATCH: begin
        capture = 1'b1;
        elem_n  = 3'd0;
        if (sym_len == 3'd0 || sym_len > 3'd5) begin
          advance = 1'b1;
        end else begin
          state_n = S_MARK;
          cnt_n   = sym_bits[0] ? DASH_LD : DOT_LD;
        end
      end
      S_MARK: begin
        if (cnt == '0) begin
          if (elem_idx == len_r - 3'd1) begin
            state_n = S_CGAP;
            cnt_n   = CGAP_LD;
          end else begin
            state_n = S_GAP;
            cnt_n   = DOT_LD;
          end
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          elem_n  = elem_idx + 3'd1;
          state_n = S_MARK;
          cnt_n   = sym_ext[elem_n] ? DASH_LD : DOT_LD;
        end
      end
      S_CGAP: begin
        if (cnt == '0) advance = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Skipped slots and finished characters share one advance path.
    if (advance) begin
      if (cur_slot == 3'd7) begin
        state_n = S_DONE;
      end else begin
        state_n = S_CHECK;
        slot_n  = cur_slot + 3'd1;
      end
    end

    if (abort && state != S_IDLE) state_n = S_IDLE;

    // Outputs are registered copies of what the next state implies.
    tone_n = (state_n == S_MARK);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
    sel_n  = (state_n == S_SELECT || state_n == S_LATCH) ? (8'h01 << slot_n) : 8'h00;
  end

endmodule

// File: tb/tb_morse_playback_sched.sv
// Testbench for morse_playback_sched: a registered encoder model answers
// slot_sel, a reference model expands each scan into per-cycle output tuples,
// collapses them into runs and queues them; a monitor collapses the observed
// outputs into runs and compares them against the queue.
module tb_morse_playback_sched;
  localparam int U   = 4;
  localparam int SET = 2;
  localparam int DU  = 3;
  localparam int CG  = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  slot_en;
  logic [63:0] seg_out_temp;
  logic [4:0]  sym_bits;
  logic [2:0]  sym_len;
  logic [7:0]  slot_sel;
  logic        tone, busy, done;
  logic [2:0]  cur_slot;

  always #5 clk = ~clk;

  morse_playback_sched #(
    .UNIT_CYCLES(U), .DASH_UNITS(DU), .CHAR_GAP_UNITS(CG), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .slot_en(slot_en),
    .seg_out_temp(seg_out_temp), .sym_bits(sym_bits), .sym_len(sym_len),
    .slot_sel(slot_sel), .tone(tone), .busy(busy), .cur_slot(cur_slot), .done(done)
  );

  typedef logic [13:0] tup_t;  // {done, busy, tone, slot_sel[7:0], cur_slot[2:0]}
  typedef struct packed { tup_t t; logic [15:0] n; } run_t;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  run_t        exp_q[$];
  tup_t        cyc_q[$];
  logic [4:0]  tab_b[8];
  logic [2:0]  tab_l[8];
  bit          mon_en = 1'b0;
  string       case_name = "reset";

  // Encoder with one cycle of latency; unselected output is deliberately bogus.
  always @(posedge clk) begin
    sym_bits <= 5'h15;
    sym_len  <= 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (slot_sel == (8'h01 << i)) begin
        sym_bits <= tab_b[i];
        sym_len  <= tab_l[i];
      end
    end
  end

  function automatic tup_t mk(input logic d, input logic b, input logic t,
                              input logic [7:0] s, input logic [2:0] c);
    return {d, b, t, s, c};
  endfunction

  // Expected behaviour of one scan, one tuple per clock cycle.
  task automatic model_push(input int cut);
    tup_t cur_t;
    int   cur_n, mark, space;
    logic [7:0] b;
    cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = seg_out_temp[i*8 +: 8];
      cyc_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'(i)));
      if (slot_en[i] && b != 8'hFF) begin
        for (int s = 0; s < SET + 1; s++)
          cyc_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h01 << i, 3'(i)));
        if (tab_l[i] >= 3'd1 && tab_l[i] <= 3'd5) begin
          for (int e = 0; e < int'(tab_l[i]); e++) begin
            mark  = tab_b[i][e] ? DU * U : U;
            space = (e == int'(tab_l[i]) - 1) ? CG * U : U;
            repeat (mark)  cyc_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'h00, 3'(i)));
            repeat (space) cyc_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 3'(i)));
          end
        end
      end
    end
    cyc_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 3'd7));
    if (cut >= 0) while (cyc_q.size() > cut + 1) void'(cyc_q.pop_back());
    cur_t = cyc_q[0];
    cur_n = 0;
    foreach (cyc_q[k]) begin
      if (cyc_q[k] == cur_t) cur_n++;
      else begin
        exp_q.push_back('{t: cur_t, n: 16'(cur_n)});
        cur_t = cyc_q[k];
        cur_n = 1;
      end
    end
    exp_q.push_back('{t: cur_t, n: 16'(cur_n)});
  endtask

  // Monitor: collapse observed active cycles into runs, compare each run.
  tup_t obs_t, run_tup;
  int   run_n = 0;
  bit   run_on = 1'b0;
  bit   act;
  run_t e_run;

  task automatic check_run();
    vec_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s extra_run: got tup=%h len=%0d, expected no run", case_name, run_tup, run_n);
    end else begin
      e_run = exp_q.pop_front();
      if (e_run.t != run_tup || int'(e_run.n) != run_n) begin
        err_cnt++;
        $display("FAIL %s run: got tup=%h len=%0d, expected tup=%h len=%0d",
                 case_name, run_tup, run_n, e_run.t, e_run.n);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs_t = mk(done, busy, tone, slot_sel, cur_slot);
      act   = busy | done;
      if (run_on && act && obs_t == run_tup) begin
        run_n++;
      end else begin
        if (run_on) check_run();
        if (act) begin
          run_tup = obs_t;
          run_n   = 1;
          run_on  = 1'b1;
        end else begin
          run_on = 1'b0;
        end
      end
      if (!act) begin
        vec_cnt++;
        if ({tone, slot_sel} != 9'h000) begin
          err_cnt++;
          $display("FAIL %s idle_outputs: got tone=%b slot_sel=%h, expected 0/00", case_name, tone, slot_sel);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s %s: got %0h, expected %0h", case_name, nm, got, exp);
    end
  endtask

  // One scan: cut>=0 aborts (or resets) after output index 'cut' is seen;
  // restart_at>=0 pulses start while busy; with_abort raises abort with start.
  task automatic run_case(input string nm, input int cut, input bit cut_rst,
                          input int restart_at, input bit with_abort);
    int k;
    case_name = nm;
    model_push(cut);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    k = 0;
    while (k < 4000 && (busy || done)) begin
      if (k == cut) begin
        if (cut_rst) rst = 1'b0;
        else         abort = 1'b1;
      end
      if (k == restart_at) start = 1'b1;
      @(negedge clk);
      rst   = 1'b1;
      abort = 1'b0;
      start = 1'b0;
      k++;
    end
    if (k >= 4000) begin
      err_cnt++;
      $display("FAIL %s timeout: busy still %b after %0d cycles, expected idle", nm, busy, k);
    end
    if (cut_rst) begin
      chk("reset_cur_slot", 32'(cur_slot), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL %s missing_runs: got %0d runs left unseen, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 8; i++) begin
      tab_b[i] = 5'd0;
      tab_l[i] = 3'd0;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    slot_en = 8'h00; seg_out_temp = 64'd0;
    clear_tabs();
    repeat (3) @(negedge clk);
    chk("slot_sel", 32'(slot_sel), 32'd0);
    chk("tone", 32'(tone), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("cur_slot", 32'(cur_slot), 32'd0);
    chk("done", 32'(done), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    case_name = "abort_idle";
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("busy", 32'(busy), 32'd0);

    // 'E' in slot 0
    slot_en = 8'h01; seg_out_temp = 64'h0000_0000_0000_0079;
    tab_l[0] = 3'd1; tab_b[0] = 5'b00000;
    run_case("E_slot0", -1, 1'b0, -1, 1'b0);

    // 'A' in slot 2
    clear_tabs();
    slot_en = 8'h04; seg_out_temp = 64'h0000_0000_0077_0000;
    tab_l[2] = 3'd2; tab_b[2] = 5'b00010;
    run_case("A_slot2", -1, 1'b0, -1, 1'b0);

    // Only slot 5 non-blank, all enabled
    clear_tabs();
    slot_en = 8'hFF; seg_out_temp = {8{8'hFF}};
    seg_out_temp[47:40] = 8'h07;
    tab_l[5] = 3'd1; tab_b[5] = 5'b00001;
    run_case("T_slot5", -1, 1'b0, -1, 1'b0);

    // Nothing enabled
    slot_en = 8'h00;
    run_case("none_enabled", -1, 1'b0, -1, 1'b0);

    // Abort mid-dash, then a fresh scan from slot 0
    clear_tabs();
    slot_en = 8'h01; seg_out_temp = 64'h0000_0000_0000_0031;
    tab_l[0] = 3'd1; tab_b[0] = 5'b00001;
    run_case("abort_dash", 9, 1'b0, -1, 1'b0);
    run_case("after_abort", -1, 1'b0, -1, 1'b0);

    // start and abort together in idle: start wins
    run_case("start_abort_same", -1, 1'b0, -1, 1'b1);

    // Reset mid-GAP of 'A' in slot 0
    clear_tabs();
    slot_en = 8'h01; seg_out_temp = 64'h0000_0000_0000_0077;
    tab_l[0] = 3'd2; tab_b[0] = 5'b00010;
    run_case("reset_gap", 9, 1'b1, -1, 1'b0);

    // start pulsed while busy must not disturb playback
    run_case("start_busy", -1, 1'b0, 6, 1'b0);

    // Illegal lengths 0 and 6 are skipped silently
    clear_tabs();
    slot_en = 8'h03; seg_out_temp = 64'h0000_0000_0000_5B06;
    tab_l[0] = 3'd0; tab_b[0] = 5'b00101;
    tab_l[1] = 3'd6; tab_b[1] = 5'b11111;
    run_case("bad_len", -1, 1'b0, -1, 1'b0);

    // Randomised scans
    for (int r = 0; r < 15; r++) begin
      slot_en = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        seg_out_temp[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        tab_b[i] = 5'($urandom);
        tab_l[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(1, 5));
      end
      run_case("random", -1, 1'b0, -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
